// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command sequencer: state encoding, command-word
// bit positions and the init-sequence successor rules.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } pic_state_e;

    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_FLAG_BIT = 4;
    localparam int OCW_SEL_BIT   = 3;
    localparam int OCW3_RIS_BIT  = 0;
    localparam int OCW3_RR_BIT   = 1;
    localparam int OCW3_SMM_BIT  = 5;
    localparam int OCW3_ESMM_BIT = 6;

    // Cascade mode (SNGL=0) needs ICW3; IC4 decides whether ICW4 follows.
    function automatic pic_state_e next_after_icw2(input logic [7:0] icw1);
        if (!icw1[ICW1_SNGL_BIT]) begin
            return WAIT_ICW3;
        end else if (icw1[ICW1_IC4_BIT]) begin
            return WAIT_ICW4;
        end else begin
            return READY;
        end
    endfunction

    function automatic pic_state_e next_after_icw3(input logic [7:0] icw1);
        if (icw1[ICW1_IC4_BIT]) begin
            return WAIT_ICW4;
        end else begin
            return READY;
        end
    endfunction

endpackage

// File: rtl/pic_wr_edge.sv
// Write-strobe falling-edge detector: one accept pulse per CS-qualified WR strobe.
// A strobe already low when reset releases is never accepted.
module pic_wr_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic cs_n_i,
    input  logic wr_n_i,
    output logic accept_o
);

    logic wr_q;
    logic armed_q;

    // Track previous WR; arm only after WR has been seen high since reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            wr_q    <= wr_n_i;
            armed_q <= armed_q | wr_n_i;
        end
    end

    assign accept_o = armed_q & wr_q & ~wr_n_i & ~cs_n_i;

endmodule

// File: rtl/pic_cmd_seq.sv
// PIC command-word sequencer: ICW1..ICW4 init sequence, OCW1..OCW3 capture in READY.
// Optional register readback is enabled by defining PIC_READBACK_EN.
module pic_cmd_seq
    import pic_pkg::*;
#(
    parameter int                  NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0]  IMR_RESET = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         globalBus,
    input  logic               A0,
    input  logic               CS,
    input  logic               WR,
    input  logic               RD,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] isr,
    output logic [7:0]         ICW1,
    output logic [7:0]         ICW2,
    output logic [7:0]         ICW3,
    output logic [7:0]         ICW4,
    output logic [7:0]         OCW2,
    output logic [7:0]         OCW3,
    output logic [NUM_IRQ-1:0] imr,
    output logic [2:0]         initState,
    output logic               initDone,
    output logic               readIsr,
    output logic               specialMask,
    output logic               ocw2Stb,
    output logic               icw1Stb,
    output logic [7:0]         dataOut,
    output logic               dataOutEn
);

    logic               accept_s;
    pic_state_e         state_q, state_d;
    logic [7:0]         icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0]         ocw2_q, ocw2_d, ocw3_q, ocw3_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d;
    logic               read_isr_q, read_isr_d, smask_q, smask_d;
    logic               ocw2_stb_q, ocw2_stb_d, icw1_stb_q, icw1_stb_d;

    pic_wr_edge u_wr_edge (
        .clk_i    (clk),
        .reset_i  (reset),
        .cs_n_i   (CS),
        .wr_n_i   (WR),
        .accept_o (accept_s)
    );

    // Decode an accepted write into next register contents and sequencer state.
    always_comb begin
        state_d    = state_q;
        icw1_d     = icw1_q;
        icw2_d     = icw2_q;
        icw3_d     = icw3_q;
        icw4_d     = icw4_q;
        ocw2_d     = ocw2_q;
        ocw3_d     = ocw3_q;
        imr_d      = imr_q;
        read_isr_d = read_isr_q;
        smask_d    = smask_q;
        ocw2_stb_d = 1'b0;
        icw1_stb_d = 1'b0;
        if (accept_s && !A0 && globalBus[ICW1_FLAG_BIT]) begin
            // ICW1 restarts initialisation from any state.
            state_d    = WAIT_ICW2;
            icw1_d     = globalBus;
            icw2_d     = 8'h00;
            icw3_d     = 8'h00;
            icw4_d     = 8'h00;
            ocw2_d     = 8'h00;
            ocw3_d     = 8'h00;
            imr_d      = '0;
            read_isr_d = 1'b0;
            smask_d    = 1'b0;
            icw1_stb_d = 1'b1;
        end else if (accept_s) begin
            case (state_q)
                IDLE: begin
                    state_d = state_q;
                end
                WAIT_ICW2: begin
                    if (A0) begin
                        icw2_d  = globalBus;
                        state_d = next_after_icw2(icw1_q);
                    end else begin
                        state_d = state_q;
                    end
                end
                WAIT_ICW3: begin
                    if (A0) begin
                        icw3_d  = globalBus;
                        state_d = next_after_icw3(icw1_q);
                    end else begin
                        state_d = state_q;
                    end
                end
                WAIT_ICW4: begin
                    if (A0) begin
                        icw4_d  = globalBus;
                        state_d = READY;
                    end else begin
                        state_d = state_q;
                    end
                end
                READY: begin
                    if (A0) begin
                        imr_d = globalBus[NUM_IRQ-1:0];
                    end else if (!globalBus[OCW_SEL_BIT]) begin
                        ocw2_d     = globalBus;
                        ocw2_stb_d = 1'b1;
                    end else begin
                        ocw3_d = globalBus;
                        if (globalBus[OCW3_RR_BIT]) begin
                            read_isr_d = globalBus[OCW3_RIS_BIT];
                        end else begin
                            read_isr_d = read_isr_q;
                        end
                        if (globalBus[OCW3_ESMM_BIT]) begin
                            smask_d = globalBus[OCW3_SMM_BIT];
                        end else begin
                            smask_d = smask_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer state and command-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            icw1_q     <= 8'h00;
            icw2_q     <= 8'h00;
            icw3_q     <= 8'h00;
            icw4_q     <= 8'h00;
            ocw2_q     <= 8'h00;
            ocw3_q     <= 8'h00;
            imr_q      <= IMR_RESET;
            read_isr_q <= 1'b0;
            smask_q    <= 1'b0;
            ocw2_stb_q <= 1'b0;
            icw1_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            icw1_q     <= icw1_d;
            icw2_q     <= icw2_d;
            icw3_q     <= icw3_d;
            icw4_q     <= icw4_d;
            ocw2_q     <= ocw2_d;
            ocw3_q     <= ocw3_d;
            imr_q      <= imr_d;
            read_isr_q <= read_isr_d;
            smask_q    <= smask_d;
            ocw2_stb_q <= ocw2_stb_d;
            icw1_stb_q <= icw1_stb_d;
        end
    end

    assign ICW1        = icw1_q;
    assign ICW2        = icw2_q;
    assign ICW3        = icw3_q;
    assign ICW4        = icw4_q;
    assign OCW2        = ocw2_q;
    assign OCW3        = ocw3_q;
    assign imr         = imr_q;
    assign initState   = state_q;
    assign initDone    = (state_q == READY);
    assign readIsr     = read_isr_q;
    assign specialMask = smask_q;
    assign ocw2Stb     = ocw2_stb_q;
    assign icw1Stb     = icw1_stb_q;

`ifdef PIC_READBACK_EN
    logic       rd_sel_s;
    logic [7:0] dout_d;
    logic [7:0] dout_q;
    logic       dout_en_q;

    // Select readback source; a simultaneous write suppresses the read.
    always_comb begin
        dout_d   = 8'h00;
        rd_sel_s = !CS && !RD && WR;
        if (rd_sel_s) begin
            if (A0) begin
                dout_d[NUM_IRQ-1:0] = imr_q;
            end else if (read_isr_q) begin
                dout_d[NUM_IRQ-1:0] = isr;
            end else begin
                dout_d[NUM_IRQ-1:0] = irr;
            end
        end else begin
            dout_d = 8'h00;
        end
    end

    // Readback data and drive enable, one clock after the read is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q    <= 8'h00;
            dout_en_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dout_en_q <= rd_sel_s;
        end
    end

    assign dataOut   = dout_q;
    assign dataOutEn = dout_en_q;
`else
    logic unused_rb;
    assign unused_rb = ^{irr, isr, RD};
    assign dataOut   = 8'h00;
    assign dataOutEn = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cmd_seq.sv
// Self-checking bench for pic_cmd_seq: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pic_cmd_seq;

    localparam int         NI      = 8;
    localparam logic [7:0] IMR_RST = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, a0, cs, wr, rd;
    logic [7:0] bus, irr, isr;
    logic [7:0] o_icw1, o_icw2, o_icw3, o_icw4, o_ocw2, o_ocw3, o_imr, o_dout;
    logic [2:0] o_state;
    logic       o_done, o_ris, o_smm, o_ocw2stb, o_icw1stb, o_douten;

    pic_cmd_seq #(.NUM_IRQ(NI), .IMR_RESET(IMR_RST)) dut (
        .clk(clk), .reset(rst), .globalBus(bus), .A0(a0), .CS(cs), .WR(wr), .RD(rd),
        .irr(irr), .isr(isr),
        .ICW1(o_icw1), .ICW2(o_icw2), .ICW3(o_icw3), .ICW4(o_icw4), .OCW2(o_ocw2), .OCW3(o_ocw3),
        .imr(o_imr), .initState(o_state), .initDone(o_done), .readIsr(o_ris),
        .specialMask(o_smm), .ocw2Stb(o_ocw2stb), .icw1Stb(o_icw1stb),
        .dataOut(o_dout), .dataOutEn(o_douten)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: init progress kept as a queue of still-expected ICW numbers.
    bit         m_started;
    int         m_pending[$];
    bit         m_prev_high;
    logic [7:0] m_icw [1:4];
    logic [7:0] m_ocw2, m_ocw3, m_imr, m_dout;
    logic       m_ris, m_smm, m_ocw2stb, m_icw1stb, m_douten;

    function automatic logic [2:0] m_state();
        if (!m_started) return 3'd0;
        if (m_pending.size() == 0) return 3'd4;
        return 3'(m_pending[0] - 1);
    endfunction

    task automatic model_edge();
        bit acc;
        bit rd_sel;
        if (rst) begin
            m_started = 1'b0; m_pending.delete(); m_prev_high = 1'b0;
            for (int i = 1; i <= 4; i++) m_icw[i] = 8'h00;
            m_ocw2 = 8'h00; m_ocw3 = 8'h00; m_imr = IMR_RST;
            m_ris = 1'b0; m_smm = 1'b0; m_ocw2stb = 1'b0; m_icw1stb = 1'b0;
            m_dout = 8'h00; m_douten = 1'b0;
            return;
        end
`ifdef PIC_READBACK_EN
        rd_sel   = !cs && !rd && wr;
        m_douten = rd_sel;
        m_dout   = !rd_sel ? 8'h00 : (a0 ? m_imr : (m_ris ? isr : irr));
`else
        rd_sel   = 1'b0;
        m_douten = rd_sel;
        m_dout   = 8'h00;
`endif
        acc = m_prev_high && !wr && !cs;
        m_ocw2stb = 1'b0;
        m_icw1stb = 1'b0;
        if (acc && !a0 && bus[4]) begin
            m_started = 1'b1;
            m_icw[1] = bus; m_icw[2] = 8'h00; m_icw[3] = 8'h00; m_icw[4] = 8'h00;
            m_ocw2 = 8'h00; m_ocw3 = 8'h00; m_imr = 8'h00; m_ris = 1'b0; m_smm = 1'b0;
            m_icw1stb = 1'b1;
            m_pending.delete();
            m_pending.push_back(2);
            if (!bus[1]) m_pending.push_back(3);
            if (bus[0]) m_pending.push_back(4);
        end else if (acc && m_started && m_pending.size() != 0) begin
            if (a0) m_icw[m_pending.pop_front()] = bus;
        end else if (acc && m_started) begin
            if (a0) m_imr = bus;
            else if (!bus[3]) begin m_ocw2 = bus; m_ocw2stb = 1'b1; end
            else begin
                m_ocw3 = bus;
                if (bus[1]) m_ris = bus[0];
                if (bus[6]) m_smm = bus[5];
            end
        end
        m_prev_high = wr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(o_state), 32'(m_state()));
        chk("initDone", 32'(o_done), 32'(m_state() == 3'd4));
        chk("ICW1", 32'(o_icw1), 32'(m_icw[1]));
        chk("ICW2", 32'(o_icw2), 32'(m_icw[2]));
        chk("ICW3", 32'(o_icw3), 32'(m_icw[3]));
        chk("ICW4", 32'(o_icw4), 32'(m_icw[4]));
        chk("OCW2", 32'(o_ocw2), 32'(m_ocw2));
        chk("OCW3", 32'(o_ocw3), 32'(m_ocw3));
        chk("imr", 32'(o_imr), 32'(m_imr));
        chk("readIsr", 32'(o_ris), 32'(m_ris));
        chk("specialMask", 32'(o_smm), 32'(m_smm));
        chk("ocw2Stb", 32'(o_ocw2stb), 32'(m_ocw2stb));
        chk("icw1Stb", 32'(o_icw1stb), 32'(m_icw1stb));
        chk("dataOut", 32'(o_dout), 32'(m_dout));
        chk("dataOutEn", 32'(o_douten), 32'(m_douten));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Full write strobe; reports the strobes seen right after the accepting edge.
    task automatic write_op(input logic a0v, input logic [7:0] busv,
                            output logic icw1_seen, output logic ocw2_seen);
        cs = 1'b0; a0 = a0v; bus = busv; wr = 1'b0;
        step();
        icw1_seen = o_icw1stb;
        ocw2_seen = o_ocw2stb;
        wr = 1'b1;
        step();
    endtask

    typedef struct {
        logic       a0;
        logic [7:0] bus;
        logic [2:0] st;
        logic [7:0] imr;
    } vec_t;

    vec_t tbl [0:9];
    logic s1, s2;
    int   pulses;

    initial begin
        tbl[0] = '{1'b0, 8'h11, 3'd1, 8'h00};
        tbl[1] = '{1'b1, 8'h20, 3'd2, 8'h00};
        tbl[2] = '{1'b1, 8'h04, 3'd3, 8'h00};
        tbl[3] = '{1'b1, 8'h01, 3'd4, 8'h00};
        tbl[4] = '{1'b0, 8'h12, 3'd1, 8'h00};
        tbl[5] = '{1'b1, 8'h40, 3'd4, 8'h00};
        tbl[6] = '{1'b1, 8'hA5, 3'd4, 8'hA5};
        tbl[7] = '{1'b0, 8'h20, 3'd4, 8'hA5};
        tbl[8] = '{1'b0, 8'h0B, 3'd4, 8'hA5};
        tbl[9] = '{1'b0, 8'h68, 3'd4, 8'hA5};

        rst = 1'b1; a0 = 1'b0; cs = 1'b1; wr = 1'b1; rd = 1'b1;
        bus = 8'h00; irr = 8'h81; isr = 8'h02;
        step();
        step();
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_imr", 32'(o_imr), 32'hFF);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            write_op(tbl[i].a0, tbl[i].bus, s1, s2);
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_imr", i), 32'(o_imr), 32'(tbl[i].imr));
            if (i == 3) begin
                chk("seq1_icw4", 32'(o_icw4), 32'h01);
                chk("seq1_done", 32'(o_done), 32'd1);
            end
            if (i == 5) chk("seq2_icw3_icw4", 32'({o_icw3, o_icw4}), 32'h0);
            if (i == 7) begin
                chk("ocw2_val", 32'(o_ocw2), 32'h20);
                chk("ocw2_pulse", 32'({s2, o_ocw2stb}), 32'b10);
            end
            if (i == 8) chk("readIsr_set", 32'(o_ris), 32'd1);
            if (i == 9) chk("smask_set", 32'(o_smm), 32'd1);
        end

        // Readback: OCW3 0x0A selects IRR, 0x0B selects ISR, A0=1 reads IMR.
        write_op(1'b0, 8'h0A, s1, s2);
        cs = 1'b0; rd = 1'b0; a0 = 1'b0;
        step();
`ifdef PIC_READBACK_EN
        chk("rb_irr", 32'({o_douten, o_dout}), 32'h181);
`else
        chk("rb_off", 32'({o_douten, o_dout}), 32'h000);
`endif
        rd = 1'b1;
        step();
        write_op(1'b0, 8'h0B, s1, s2);
        rd = 1'b0;
        step();
`ifdef PIC_READBACK_EN
        chk("rb_isr", 32'({o_douten, o_dout}), 32'h102);
`endif
        a0 = 1'b1;
        step();
`ifdef PIC_READBACK_EN
        chk("rb_imr", 32'({o_douten, o_dout}), 32'h1A5);
`endif
        wr = 1'b0; a0 = 1'b0; bus = 8'h0A;
        step();
        chk("rd_wr_collision", 32'(o_douten), 32'd0);
        rd = 1'b1; wr = 1'b1;
        step();

        // WR held low for five cycles: exactly one ICW1 acceptance.
        pulses = 0;
        cs = 1'b0; a0 = 1'b0; bus = 8'h13; wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(o_icw1stb);
        end
        chk("held_wr_pulses", 32'(pulses), 32'd1);
        wr = 1'b1;
        step();
        write_op(1'b1, 8'h20, s1, s2);
        chk("sngl_ic4_state", 32'(o_state), 32'd3);
        write_op(1'b1, 8'h03, s1, s2);
        write_op(1'b1, 8'h5A, s1, s2);
        write_op(1'b0, 8'h11, s1, s2);
        write_op(1'b1, 8'h08, s1, s2);
        chk("cascade_state", 32'(o_state), 32'd2);
        write_op(1'b0, 8'h11, s1, s2);
        chk("restart_state", 32'(o_state), 32'd1);
        chk("restart_imr", 32'(o_imr), 32'h00);
        chk("restart_strobe", 32'(s1), 32'd1);

        // Reset in WAIT_ICW2 with WR low; the held strobe must not be accepted.
        cs = 1'b0; a0 = 1'b0; bus = 8'h11; wr = 1'b0; rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(o_icw1stb);
        end
        chk("rst_hold_pulses", 32'(pulses), 32'd0);
        chk("rst_hold_state", 32'(o_state), 32'd0);
        chk("rst_hold_imr", 32'(o_imr), 32'hFF);
        wr = 1'b1;
        step();
        wr = 1'b0;
        step();
        chk("rst_rearm_state", 32'(o_state), 32'd1);
        wr = 1'b1;
        step();

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            cs  = ($urandom_range(0, 7) == 0);
            wr  = ($urandom_range(0, 1) == 0);
            rd  = ($urandom_range(0, 1) == 0);
            a0  = ($urandom_range(0, 1) == 0);
            irr = 8'($urandom);
            isr = 8'($urandom);
            bus = 8'($urandom);
            if (!a0) begin
                if ($urandom_range(0, 11) == 0) bus = bus | 8'h10;
                else bus = bus & 8'hEF;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
